// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit validation, LSB-first data assembly,
// optional even parity and stop-bit check, one-cycle result strobes.
// Optional parity bit and parity_err_o port: define UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned DataWidth      = 8,
   parameter int unsigned OversampleRate = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tick_i,
   input  logic                 rxd_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 dv_o,
   output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err_o,
`endif
   output logic                 busy_o
);

   localparam int unsigned OsW  = $clog2(OversampleRate);
   localparam int unsigned BitW = $clog2(DataWidth + 1);

   localparam logic [OsW-1:0]  OsMid   = OsW'(OversampleRate / 2 - 1);
   localparam logic [OsW-1:0]  OsLast  = OsW'(OversampleRate - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(DataWidth - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   logic [OsW-1:0]       os_q, os_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 dv_q, dv_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q;
   logic                 fall;
   logic                 os_last;
`ifdef UART_RX_PARITY_EN
   logic                 par_err_q, par_err_d;
   logic                 perr_q, perr_d;
`endif

   // Previous-high / current-low only, so a held-low break never starts a frame.
   assign fall    = rx_prev_q & ~rx_sync_q;
   assign os_last = tick_i && (os_q == OsLast);

   // Next-state, counters, shift register and result strobes.
   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (fall) begin
               os_d    = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (tick_i) begin
               if (os_q == OsMid) begin
                  if (!rx_sync_q) begin
                     os_d    = '0;
                     bit_d   = '0;
                     state_d = StData;
                  end else begin
                     state_d = StIdle;  // glitch, not a real start bit
                  end
               end else begin
                  os_d = os_q + OsW'(1);
               end
            end
         end
         StData: begin
            if (os_last) begin
               os_d    = '0;
               shift_d = {rx_sync_q, shift_q[DataWidth-1:1]};
               bit_d   = bit_q + BitW'(1);
               if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end else if (tick_i) begin
               os_d = os_q + OsW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (os_last) begin
               os_d      = '0;
               par_err_d = rx_sync_q ^ (^shift_q);
               state_d   = StStop;
            end else if (tick_i) begin
               os_d = os_q + OsW'(1);
            end
         end
`endif
         StStop: begin
            if (os_last) begin
               os_d    = '0;
               data_d  = shift_q;
               state_d = StIdle;
               if (!rx_sync_q) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_err_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  dv_d = 1'b1;
               end
            end else if (tick_i) begin
               os_d = os_q + OsW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, synchronizer and registered outputs; synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         os_q      <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rxd_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         os_q      <= os_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         ferr_q    <= ferr_d;
         busy_q    <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign data_o      = data_q;
   assign dv_o        = dv_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-written corner sequences,
// results checked through an expected-result queue.
module tb_uart_rx;

   localparam int ClksPerTick = 4;
   localparam int BitClks     = 16 * ClksPerTick;

   localparam logic [2:0] KDv   = 3'b001;
   localparam logic [2:0] KFerr = 3'b010;
   localparam logic [2:0] KPerr = 3'b100;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       flip;
      logic [2:0] kind;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data;
   logic       dv, ferr, perr, busy;

   int   total = 0;
   int   bad = 0;
   int   tick_cnt = 0;
   exp_t q[$];
   vec_t vecs[6];

   uart_rx #(
      .DataWidth(8),
      .OversampleRate(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .tick_i(tick),
      .rxd_i(rxd),
      .data_o(data),
      .dv_o(dv),
      .frame_err_o(ferr),
`ifdef UART_RX_PARITY_EN
      .parity_err_o(perr),
`endif
      .busy_o(busy)
   );

`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

   always #5 clk = ~clk;

   // Oversample strobe: one clock wide every ClksPerTick clocks.
   initial begin
      forever begin
         @(negedge clk);
         tick = (tick_cnt == ClksPerTick - 1);
         tick_cnt = (tick_cnt + 1) % ClksPerTick;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every result pulse must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (dv || ferr || perr)) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", {29'd0, perr, ferr, dv}, 32'd0);
         end else begin
            e = q.pop_front();
            check("result_kind", {29'd0, perr, ferr, dv}, {29'd0, e.kind});
            check("result_data", {24'd0, data}, {24'd0, e.data});
            check("busy_at_result", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      wait_clks(BitClks);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ flip);
`endif
      send_bit(stop);
   endtask

   task automatic push(input logic [2:0] k, input logic [7:0] d);
      q.push_back('{kind: k, data: d});
   endtask

   task automatic drained(input string name);
      check(name, q.size(), 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, stop: 1'b1, flip: 1'b0, kind: KDv};
      vecs[1] = '{data: 8'h5A, stop: 1'b0, flip: 1'b0, kind: KFerr};
      vecs[2] = '{data: 8'hC3, stop: 1'b1, flip: 1'b0, kind: KDv};
`ifdef UART_RX_PARITY_EN
      vecs[3] = '{data: 8'h07, stop: 1'b1, flip: 1'b1, kind: KPerr};
`else
      vecs[3] = '{data: 8'h07, stop: 1'b1, flip: 1'b1, kind: KDv};
`endif
      vecs[4] = '{data: 8'h07, stop: 1'b1, flip: 1'b0, kind: KDv};
      vecs[5] = '{data: 8'h01, stop: 1'b1, flip: 1'b0, kind: KDv};

      // Reset state.
      wait_clks(4);
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_strobes", {29'd0, perr, ferr, dv}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      wait_clks(BitClks);

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].kind, vecs[i].data);
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].flip);
         rxd = 1'b1;
         wait_clks(2 * BitClks);
         drained($sformatf("vec%0d_drained", i));
      end

      // Glitch: low for 4 ticks only.
      rxd = 1'b0;
      wait_clks(8);
      check("glitch_busy_rise", {31'd0, busy}, 32'd1);
      wait_clks(4 * ClksPerTick - 8);
      rxd = 1'b1;
      wait_clks(2 * BitClks);
      check("glitch_data_kept", {24'd0, data}, 32'h01);
      drained("glitch_drained");

      // Frame error followed by a held-low break, then a clean frame.
      push(KFerr, 8'h3C);
      send_frame(8'h3C, 1'b0, 1'b0);
      wait_clks(3 * BitClks);
      check("break_no_start", {31'd0, busy}, 32'd0);
      rxd = 1'b1;
      wait_clks(BitClks);
      push(KDv, 8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      rxd = 1'b1;
      wait_clks(2 * BitClks);
      drained("break_drained");

      // Back-to-back frames with no idle gap.
      push(KDv, 8'h00);
      push(KDv, 8'hFF);
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      rxd = 1'b1;
      wait_clks(2 * BitClks);
      drained("b2b_drained");

      // Reset in the middle of data bit 4 of 0x5A.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0);
      rxd = 1'b1;
      wait_clks(BitClks / 2);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      wait_clks(1);
      check("midrst_data", {24'd0, data}, 32'd0);
      check("midrst_strobes", {29'd0, perr, ferr, dv}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      wait_clks(12 * BitClks);
      drained("midrst_quiet");
      push(KDv, 8'h12);
      send_frame(8'h12, 1'b1, 1'b0);
      rxd = 1'b1;
      wait_clks(2 * BitClks);
      drained("post_rst_drained");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
